// File: rtl/enoc_switch_allocator.sv
// enoc_switch_allocator
// Per-router output-port allocator. Every output owns a round-robin arbiter
// that picks one requesting input queue whenever the output register is free.
// The winning input is popped combinationally through o_grant. The crossbar
// select and the output-valid flag are registered one edge later.

module enoc_switch_allocator #(
   parameter int N     = 7,
   parameter int M     = 7,
   parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [0:N-1][0:M-1]      i_req,
   input  logic [0:M-1]             i_en,
   output logic [0:N-1]             o_grant,
   output logic [0:M-1][SEL_W-1:0]  o_sel,
   output logic [0:M-1]             o_data_val
);

   logic [0:N-1][0:M-1]     w_effReq;
   logic [0:M-1]            w_free;
   logic [0:M-1]            w_winVal;
   logic [0:M-1][SEL_W-1:0] w_winIdx;

   logic [0:M-1][SEL_W-1:0] r_sel;
   logic [0:M-1][SEL_W-1:0] r_ptr;
   logic [0:M-1]            r_dataVal;

   assign o_sel      = r_sel;
   assign o_data_val = r_dataVal;

   // Reduce each request row to its lowest-index output so that a malformed
   // multi-bit row can never be granted by two outputs at once
   always_comb begin
      w_effReq = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = M - 1; j >= 0; j--) begin
            if (i_req[i][j]) begin
               w_effReq[i]    = '0;
               w_effReq[i][j] = 1'b1;
            end
         end
      end
   end

   // An output can accept a new winner when its register is empty or draining
   always_comb begin
      w_free = '0;
      for (int j = 0; j < M; j++) begin
         w_free[j] = !r_dataVal[j] || i_en[j];
      end
   end

   // Round-robin search starting at the pointer: the wrapped region below the
   // pointer is scanned first so that any hit at or above the pointer overrides it
   always_comb begin
      w_winVal = '0;
      w_winIdx = '0;
      for (int j = 0; j < M; j++) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (w_free[j] && (i < int'(r_ptr[j])) && w_effReq[i][j]) begin
               w_winVal[j] = 1'b1;
               w_winIdx[j] = SEL_W'(i);
            end
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (w_free[j] && (i >= int'(r_ptr[j])) && w_effReq[i][j]) begin
               w_winVal[j] = 1'b1;
               w_winIdx[j] = SEL_W'(i);
            end
         end
      end
   end

   // Dequeue strobe: an input is popped when it won some output, never during reset
   always_comb begin
      o_grant = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < M; j++) begin
            if (!reset && w_winVal[j] && (w_winIdx[j] == SEL_W'(i))) begin
               o_grant[i] = 1'b1;
            end
         end
      end
   end

   // Load the output registers and advance the pointers past each winner,
   // wrapping explicitly since N need not be a power of two
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dataVal <= '0;
         r_sel     <= '0;
         r_ptr     <= '0;
      end else begin
         for (int j = 0; j < M; j++) begin
            if (w_winVal[j]) begin
               r_dataVal[j] <= 1'b1;
               r_sel[j]     <= w_winIdx[j];
               if (w_winIdx[j] == SEL_W'(N - 1)) begin
                  r_ptr[j] <= '0;
               end else begin
                  r_ptr[j] <= w_winIdx[j] + SEL_W'(1);
               end
            end else begin
               r_dataVal[j] <= r_dataVal[j] && !i_en[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// tb_enoc_switch_allocator
// Directed bench for the switch allocator: reset behaviour, single grants,
// round-robin rotation, backpressure, parallel outputs, malformed request rows
// and a mid-operation reset.

module tb_enoc_switch_allocator;

   localparam int N     = 7;
   localparam int M     = 7;
   localparam int SEL_W = 3;

   logic                     clk;
   logic                     reset;
   logic [0:N-1][0:M-1]      req;
   logic [0:M-1]             en;
   logic [0:N-1]             grant;
   logic [0:M-1][SEL_W-1:0]  sel;
   logic [0:M-1]             dataVal;

   int compared;
   int mismatched;

   enoc_switch_allocator #(.N(N), .M(M)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (req),
      .i_en       (en),
      .o_grant    (grant),
      .o_sel      (sel),
      .o_data_val (dataVal)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [0:N-1] inBit(input int i);
      logic [0:N-1] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [0:M-1] outBit(input int j);
      logic [0:M-1] v;
      v    = '0;
      v[j] = 1'b1;
      return v;
   endfunction

   task automatic applyStimulus(input logic [0:N-1][0:M-1] r, input logic [0:M-1] e);
      req = r;
      en  = e;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Linear sequence of directed steps; inputs change 1 after an edge, checks follow
   initial begin
      logic [0:N-1][0:M-1] rv;
      logic [0:M-1]        ev;
      compared   = 0;
      mismatched = 0;

      $display("[TB] reset held with all requests and enables high");
      reset = 1'b1;
      rv    = '1;
      applyStimulus(rv, '1);
      #1;
      repeat (3) begin
         checkOutput("rst_grant", 32'(grant), 32'd0);
         checkOutput("rst_val", 32'(dataVal), 32'd0);
         checkOutput("rst_sel", 32'(sel), 32'd0);
         tick();
      end

      $display("[TB] first arbitration after reset goes to input 0");
      reset = 1'b0;
      #1;
      checkOutput("post_rst_grant", 32'(grant), 32'(inBit(0)));
      tick();
      checkOutput("post_rst_val", 32'(dataVal), 32'(outBit(0)));
      rv = '0;
      applyStimulus(rv, '1);
      #1;
      checkOutput("idle_grant", 32'(grant), 32'd0);
      tick();
      checkOutput("drain_val", 32'(dataVal), 32'd0);

      $display("[TB] single request input 3 -> output 2");
      rv       = '0;
      rv[3][2] = 1'b1;
      applyStimulus(rv, '1);
      #1;
      checkOutput("single_grant", 32'(grant), 32'(inBit(3)));
      tick();
      checkOutput("single_val", 32'(dataVal), 32'(outBit(2)));
      checkOutput("single_sel", 32'(sel[2]), 32'd3);
      rv[4][2] = 1'b1;
      applyStimulus(rv, '1);
      #1;
      checkOutput("ptr_adv_grant", 32'(grant), 32'(inBit(4)));
      tick();
      checkOutput("ptr_adv_sel", 32'(sel[2]), 32'd4);
      checkOutput("ptr_adv_val", 32'(dataVal), 32'(outBit(2)));
      rv = '0;
      applyStimulus(rv, '1);
      tick();
      checkOutput("drain2_val", 32'(dataVal), 32'd0);

      $display("[TB] round robin on output 1 with all inputs requesting");
      rv = '0;
      for (int i = 0; i < N; i++) rv[i][1] = 1'b1;
      applyStimulus(rv, '1);
      for (int k = 0; k < 8; k++) begin
         #1;
         checkOutput("rr_grant", 32'(grant), 32'(inBit(k % N)));
         tick();
         checkOutput("rr_sel", 32'(sel[1]), 32'(k % N));
         checkOutput("rr_val", 32'(dataVal), 32'(outBit(1)));
      end

      $display("[TB] backpressure on output 1");
      rv       = '0;
      rv[2][1] = 1'b1;
      applyStimulus(rv, '1);
      #1;
      checkOutput("bp_load_grant", 32'(grant), 32'(inBit(2)));
      tick();
      checkOutput("bp_load_sel", 32'(sel[1]), 32'd2);
      rv       = '0;
      rv[4][1] = 1'b1;
      ev       = '1;
      ev[1]    = 1'b0;
      applyStimulus(rv, ev);
      repeat (3) begin
         #1;
         checkOutput("bp_hold_grant", 32'(grant), 32'd0);
         checkOutput("bp_hold_sel", 32'(sel[1]), 32'd2);
         checkOutput("bp_hold_val", 32'(dataVal), 32'(outBit(1)));
         tick();
      end
      applyStimulus(rv, '1);
      #1;
      checkOutput("bp_release_grant", 32'(grant), 32'(inBit(4)));
      tick();
      checkOutput("bp_release_sel", 32'(sel[1]), 32'd4);
      checkOutput("bp_release_val", 32'(dataVal), 32'(outBit(1)));
      rv = '0;
      applyStimulus(rv, '1);
      tick();
      checkOutput("drain3_val", 32'(dataVal), 32'd0);

      $display("[TB] parallel grants and conflict on output 4");
      rv       = '0;
      rv[0][4] = 1'b1;
      rv[5][4] = 1'b1;
      rv[2][0] = 1'b1;
      applyStimulus(rv, '1);
      #1;
      checkOutput("par_grant1", 32'(grant), 32'(inBit(0) | inBit(2)));
      tick();
      checkOutput("par_sel4", 32'(sel[4]), 32'd0);
      checkOutput("par_sel0", 32'(sel[0]), 32'd2);
      checkOutput("par_val", 32'(dataVal), 32'(outBit(0) | outBit(4)));
      rv[0][4] = 1'b0;
      rv[2][0] = 1'b0;
      applyStimulus(rv, '1);
      #1;
      checkOutput("par_grant2", 32'(grant), 32'(inBit(5)));
      tick();
      checkOutput("par_sel4_2", 32'(sel[4]), 32'd5);
      rv = '0;
      applyStimulus(rv, '1);
      tick();
      checkOutput("drain4_val", 32'(dataVal), 32'd0);

      $display("[TB] malformed row: input 1 requests outputs 2 and 4");
      rv       = '0;
      rv[1][2] = 1'b1;
      rv[1][4] = 1'b1;
      applyStimulus(rv, '1);
      #1;
      checkOutput("multi_grant", 32'(grant), 32'(inBit(1)));
      tick();
      checkOutput("multi_val", 32'(dataVal), 32'(outBit(2)));
      checkOutput("multi_sel", 32'(sel[2]), 32'd1);

      $display("[TB] reset in the middle of operation");
      rv    = '0;
      ev    = '1;
      ev[2] = 1'b0;
      applyStimulus(rv, ev);
      #1;
      checkOutput("pre_midrst_val", 32'(dataVal), 32'(outBit(2)));
      rv       = '0;
      rv[0][2] = 1'b1;
      rv[6][2] = 1'b1;
      applyStimulus(rv, '1);
      reset = 1'b1;
      #1;
      checkOutput("midrst_val", 32'(dataVal), 32'd0);
      checkOutput("midrst_grant", 32'(grant), 32'd0);
      checkOutput("midrst_sel", 32'(sel), 32'd0);
      tick();
      checkOutput("midrst_grant2", 32'(grant), 32'd0);
      reset = 1'b0;
      #1;
      checkOutput("after_midrst_grant", 32'(grant), 32'(inBit(0)));
      tick();
      checkOutput("after_midrst_val", 32'(dataVal), 32'(outBit(2)));
      checkOutput("after_midrst_sel", 32'(sel[2]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
